// File: rtl/beep_pkg.sv
// beep_pkg: shared types, period windows and the period classifier for
// beep_decoder. Window constants assume a 100 MHz system clock.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        LOCK_512 = 2'd2,
        LOCK_1K  = 2'd3
    } beep_state_t;

    typedef enum logic [1:0] {
        C512    = 2'd0,
        C1K     = 2'd1,
        INVALID = 2'd2
    } beep_class_t;

    // Inclusive period windows in clk cycles.
    localparam int unsigned P512_MIN = 185_000;
    localparam int unsigned P512_MAX = 205_000;
    localparam int unsigned P1K_MIN  = 95_000;
    localparam int unsigned P1K_MAX  = 105_000;

    // Measured periods are per + 1, so one bit wider than the 18-bit counter.
    localparam int PERIOD_W = 19;

    function automatic beep_class_t classify(
        input logic [PERIOD_W-1:0] p,
        input logic [PERIOD_W-1:0] lo512,
        input logic [PERIOD_W-1:0] hi512,
        input logic [PERIOD_W-1:0] lo1k,
        input logic [PERIOD_W-1:0] hi1k
    );
        if (p >= lo512 && p <= hi512) begin
            return C512;
        end else if (p >= lo1k && p <= hi1k) begin
            return C1K;
        end else begin
            return INVALID;
        end
    endfunction

endpackage

// File: rtl/beep_edge_sync.sv
// beep_edge_sync: 2-FF synchronizer, optional stability filter and
// rising-edge detector for the asynchronous beeper line.
// Macro BEEP_DECODER_GLITCH_FILTER_EN: when defined, the level only changes
// after 4 identical consecutive synchronized samples (pin-to-pulse latency 7
// cycles instead of 3).
module beep_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic beep_in,
    output logic rise_pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    // Two flops to resolve metastability on the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= beep_in;
            sync2 <= sync1;
        end
    end

`ifdef BEEP_DECODER_GLITCH_FILTER_EN
    logic [1:0] stab_cnt;
    logic       filt;

    // Adopt a new level only once it has been seen on 4 consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt     <= 1'b0;
            stab_cnt <= 2'd0;
        end else if (sync2 == filt) begin
            stab_cnt <= 2'd0;
        end else if (stab_cnt == 2'd3) begin
            filt     <= sync2;
            stab_cnt <= 2'd0;
        end else begin
            stab_cnt <= stab_cnt + 2'd1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Registered one-cycle pulse on each low-to-high transition of the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            level_d    <= level;
            rise_pulse <= level & ~level_d;
        end
    end

endmodule

// File: rtl/beep_decoder.sv
// beep_decoder: measures the period between rising edges of a beeper line,
// classifies it as 512 Hz / 1 kHz / invalid and locks onto a tone after
// LOCK_CNT consecutive same-class periods.
// Macro BEEP_DECODER_GLITCH_FILTER_EN enables the input stability filter
// inside beep_edge_sync.
// The P*_LO/P*_HI parameters default to the package windows; they exist so a
// scaled-down instance can be built for short simulations.
module beep_decoder
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 250_000,
    parameter int unsigned P512_LO  = P512_MIN,
    parameter int unsigned P512_HI  = P512_MAX,
    parameter int unsigned P1K_LO   = P1K_MIN,
    parameter int unsigned P1K_HI   = P1K_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        beep_in,
    output logic        tone_512,
    output logic        tone_1k,
    output logic        tone_start,
    output logic        tone_end,
    output logic [15:0] burst_len,
    output beep_state_t state_dbg
);

    if (CLK_HZ == 0 || LOCK_CNT == 0 || LOCK_CNT > 255 ||
        TIMEOUT < 2 || TIMEOUT > 262_143) begin : g_bad_param
        $error("beep_decoder: parameter out of range");
    end

    localparam logic [17:0]         TO_MAX     = 18'(TIMEOUT);
    localparam logic [17:0]         TO_LAST    = 18'(TIMEOUT - 1);
    localparam logic [7:0]          LOCK_N     = 8'(LOCK_CNT);
    localparam logic [15:0]         LOCK_BURST = 16'(LOCK_CNT);
    localparam logic [PERIOD_W-1:0] W512_LO    = PERIOD_W'(P512_LO);
    localparam logic [PERIOD_W-1:0] W512_HI    = PERIOD_W'(P512_HI);
    localparam logic [PERIOD_W-1:0] W1K_LO     = PERIOD_W'(P1K_LO);
    localparam logic [PERIOD_W-1:0] W1K_HI     = PERIOD_W'(P1K_HI);

    logic                rise;
    logic [17:0]         per;
    logic [PERIOD_W-1:0] period;
    beep_class_t         cls;
    beep_class_t         prev_cls;
    logic [7:0]          match_cnt;
    logic [7:0]          match_next;
    logic                timeout_hit;
    beep_state_t         state;

    beep_edge_sync u_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .beep_in    (beep_in),
        .rise_pulse (rise)
    );

    // Period classification and the match count the current edge would produce.
    always_comb begin
        period      = {1'b0, per} + PERIOD_W'(1);
        cls         = classify(period, W512_LO, W512_HI, W1K_LO, W1K_HI);
        match_next  = 8'd0;
        if (cls == INVALID) begin
            match_next = 8'd0;
        end else if (cls == prev_cls) begin
            match_next = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;
        end else begin
            match_next = 8'd1;
        end
        // Fires once, on the cycle per steps onto TIMEOUT; an edge wins.
        timeout_hit = !rise && (per == TO_LAST);
    end

    // Cycles since the last edge, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            per <= 18'd0;
        end else if (rise) begin
            per <= 18'd0;
        end else if (per != TO_MAX) begin
            per <= per + 18'd1;
        end
    end

    // Tone FSM with registered tone levels, pulses and burst length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            match_cnt  <= 8'd0;
            prev_cls   <= INVALID;
            burst_len  <= 16'd0;
            tone_512   <= 1'b0;
            tone_1k    <= 1'b0;
            tone_start <= 1'b0;
            tone_end   <= 1'b0;
        end else begin
            tone_start <= 1'b0;
            tone_end   <= 1'b0;
            if (rise) begin
                case (state)
                    IDLE: begin
                        // First edge only opens the measurement window.
                        state     <= MEASURE;
                        match_cnt <= 8'd0;
                        prev_cls  <= INVALID;
                        burst_len <= 16'd0;
                    end
                    MEASURE: begin
                        match_cnt <= match_next;
                        prev_cls  <= cls;
                        if (match_next >= LOCK_N && cls == C512) begin
                            state      <= LOCK_512;
                            tone_512   <= 1'b1;
                            tone_start <= 1'b1;
                            burst_len  <= LOCK_BURST;
                        end else if (match_next >= LOCK_N && cls == C1K) begin
                            state      <= LOCK_1K;
                            tone_1k    <= 1'b1;
                            tone_start <= 1'b1;
                            burst_len  <= LOCK_BURST;
                        end
                    end
                    LOCK_512: begin
                        match_cnt <= match_next;
                        prev_cls  <= cls;
                        if (cls == C512) begin
                            if (burst_len != 16'hFFFF) burst_len <= burst_len + 16'd1;
                        end else begin
                            state    <= MEASURE;
                            tone_512 <= 1'b0;
                            tone_end <= 1'b1;
                        end
                    end
                    default: begin
                        match_cnt <= match_next;
                        prev_cls  <= cls;
                        if (cls == C1K) begin
                            if (burst_len != 16'hFFFF) burst_len <= burst_len + 16'd1;
                        end else begin
                            state    <= MEASURE;
                            tone_1k  <= 1'b0;
                            tone_end <= 1'b1;
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                state     <= IDLE;
                match_cnt <= 8'd0;
                prev_cls  <= INVALID;
                tone_512  <= 1'b0;
                tone_1k   <= 1'b0;
                if (state == LOCK_512 || state == LOCK_1K) tone_end <= 1'b1;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_beep_decoder.sv
// tb_beep_decoder: directed bench for beep_decoder on a scaled instance
// (windows and timeout divided by 1000). tone_start/tone_end events are
// matched against an expected queue; levels are checked at fixed points.
module tb_beep_decoder;
    import beep_pkg::*;

    localparam int TIMEOUT = 250;
`ifdef BEEP_DECODER_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 7;
`else
    localparam int EDGE_LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        beep_in;
    logic        tone_512;
    logic        tone_1k;
    logic        tone_start;
    logic        tone_end;
    logic [15:0] burst_len;
    beep_state_t state_dbg;

    int errors = 0;
    int checks = 0;
    logic [19:0] exp_q[$];
    logic        both_high_seen = 1'b0;

    beep_decoder #(
        .LOCK_CNT (4),
        .TIMEOUT  (TIMEOUT),
        .P512_LO  (185),
        .P512_HI  (205),
        .P1K_LO   (95),
        .P1K_HI   (105)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .beep_in    (beep_in),
        .tone_512   (tone_512),
        .tone_1k    (tone_1k),
        .tone_start (tone_start),
        .tone_end   (tone_end),
        .burst_len  (burst_len),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event word: {end, start, tone_512, tone_1k, burst_len}
    function automatic logic [19:0] ev(input logic is_end, input logic t512,
                                       input logic t1k, input logic [15:0] burst);
        return {is_end, ~is_end, t512, t1k, burst};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_periods(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            beep_in = 1'b1;
            cycles(period / 2);
            beep_in = 1'b0;
            cycles(period - period / 2);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (state_dbg !== IDLE && n < 2 * TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state_dbg === IDLE), 32'd1);
    endtask

    // Scoreboard monitor: every start/end pulse must match the queue head.
    always @(negedge clk) begin
        logic [19:0] obs;
        if (tone_512 === 1'b1 && tone_1k === 1'b1) both_high_seen = 1'b1;
        if (rst === 1'b0 && (tone_start === 1'b1 || tone_end === 1'b1)) begin
            obs = {tone_end, tone_start, tone_512, tone_1k, burst_len};
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(obs), 32'd0);
            end else begin
                check("event", 32'(obs), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        // Reset
        rst     = 1'b1;
        beep_in = 1'b1;
        cycles(5);
        check("rst_tone_512", 32'(tone_512), 32'd0);
        check("rst_tone_1k", 32'(tone_1k), 32'd0);
        check("rst_start", 32'(tone_start), 32'd0);
        check("rst_end", 32'(tone_end), 32'd0);
        check("rst_burst", 32'(burst_len), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        beep_in = 1'b0;
        rst     = 1'b0;
        cycles(10);

        // 1 kHz: lock on the 5th edge, burst 4, then +1 on the 6th edge
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 16'd4));
        drive_periods(4, 100);
        beep_in = 1'b1;
        cycles(EDGE_LAT + 1);
        check("k1_start", 32'(tone_start), 32'd1);
        check("k1_tone_1k", 32'(tone_1k), 32'd1);
        check("k1_tone_512", 32'(tone_512), 32'd0);
        check("k1_burst_lock", 32'(burst_len), 32'd4);
        cycles(50 - (EDGE_LAT + 1));
        beep_in = 1'b0;
        cycles(50);
        drive_periods(1, 100);
        check("k1_burst_6th", 32'(burst_len), 32'd5);
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 16'd5));
        wait_idle("k1_idle");

        // 512 Hz: 10 edges then low; tone_end exactly after the timeout
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 16'd4));
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 16'd9));
        drive_periods(9, 195);
        beep_in = 1'b1;
        n = 0;
        while (tone_end !== 1'b1 && n < 2 * TIMEOUT + 50) begin
            @(negedge clk);
            n++;
            if (n == 97) beep_in = 1'b0;
            if (n == 100) begin
                check("s512_tone", 32'(tone_512), 32'd1);
                check("s512_burst", 32'(burst_len), 32'd9);
            end
        end
        check("s512_end_delay", 32'(n), 32'(TIMEOUT + EDGE_LAT + 1));
        check("s512_tone_off", 32'(tone_512), 32'd0);
        check("s512_burst_hold", 32'(burst_len), 32'd9);
        check("s512_state", 32'(state_dbg), 32'(IDLE));
        cycles(5);

        // 1 kHz lock, then switch to the 512 Hz period
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 16'd4));
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 16'd5));
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 16'd4));
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 16'd4));
        drive_periods(5, 100);
        check("sw_tone_1k", 32'(tone_1k), 32'd1);
        drive_periods(5, 195);
        check("sw_tone_512", 32'(tone_512), 32'd1);
        check("sw_tone_1k_off", 32'(tone_1k), 32'd0);
        check("sw_burst", 32'(burst_len), 32'd4);
        wait_idle("sw_idle");
        check("sw_exclusive", 32'(both_high_seen), 32'd0);

        // Out-of-window periods never lock
        drive_periods(8, 150);
        check("inv_state", 32'(state_dbg), 32'(MEASURE));
        check("inv_tone_512", 32'(tone_512), 32'd0);
        check("inv_tone_1k", 32'(tone_1k), 32'd0);
        check("inv_burst", 32'(burst_len), 32'd0);
        wait_idle("inv_idle");

        // Reset during a 1 kHz lock: tone drops, no tone_end
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 16'd4));
        drive_periods(5, 100);
        check("rlk_tone_1k", 32'(tone_1k), 32'd1);
        rst = 1'b1;
        cycles(1);
        check("rlk_tone_off", 32'(tone_1k), 32'd0);
        check("rlk_no_end", 32'(tone_end), 32'd0);
        check("rlk_burst", 32'(burst_len), 32'd0);
        rst = 1'b0;
        cycles(1);
        check("rlk_no_end_after", 32'(tone_end), 32'd0);
        cycles(5);

        // 2-cycle glitches, two per 100-cycle frame (spacings 30/70)
        for (int i = 0; i < 6; i++) begin
            beep_in = 1'b1;
            cycles(2);
            beep_in = 1'b0;
            cycles(28);
            beep_in = 1'b1;
            cycles(2);
            beep_in = 1'b0;
            cycles(68);
        end
`ifdef BEEP_DECODER_GLITCH_FILTER_EN
        check("glitch_state", 32'(state_dbg), 32'(IDLE));
`else
        check("glitch_state", 32'(state_dbg), 32'(MEASURE));
`endif
        check("glitch_tone_1k", 32'(tone_1k), 32'd0);
        check("glitch_tone_512", 32'(tone_512), 32'd0);
        wait_idle("glitch_idle");

        cycles(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
